// File: rtl/dino_pkg.sv
// Shared encodings for the dino motion controller and the sprite-select FSM.
package dino_pkg;

  // Default physics constants (pixels, pixels/frame).
  localparam int DINO_Y_W     = 8;
  localparam int DINO_V_W     = 6;
  localparam int DINO_JUMP_V0 = 12;
  localparam int DINO_GRAVITY = 1;
  localparam int DINO_FAST_G  = 2;
  localparam int DINO_CUT_V   = 4;
  localparam int DINO_MAX_H   = 100;

  // Global game state as driven by the game-flow controller; 2'b11 behaves like start.
  typedef enum logic [1:0] {
    GS_START = 2'b00,
    GS_OVER  = 2'b01,
    GS_PLAY  = 2'b10
  } game_state_e;

  // Vertical-motion phase of the dino.
  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_DUCK   = 2'b01,
    ST_RISE   = 2'b10,
    ST_FALL   = 2'b11
  } motion_state_e;

  // Sprite-select codes shared with the sprite FSM.
  typedef enum logic [1:0] {
    SPR_RUN  = 2'b00,
    SPR_DUCK = 2'b01,
    SPR_JUMP = 2'b10,
    SPR_DEAD = 2'b11
  } sprite_e;

  // True while the dino is off the ground.
  function automatic logic is_air(input motion_state_e s);
    return (s == ST_RISE) || (s == ST_FALL);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop button synchronizer plus a frame-gated previous-value register,
// giving a clean level and a once-per-frame rising edge.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronize the raw button; sample the previous level only on frame ticks.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (tick) prev_q <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Per-frame vertical-motion controller: jump physics, ground/air/duck flags
// and the dino height for the renderer and collision logic.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int Y_W     = DINO_Y_W,
  parameter int V_W     = DINO_V_W,
  parameter int JUMP_V0 = DINO_JUMP_V0,
  parameter int GRAVITY = DINO_GRAVITY,
  parameter int FAST_G  = DINO_FAST_G,
  parameter int CUT_V   = DINO_CUT_V,
  parameter int MAX_H   = DINO_MAX_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frameTick,
  input  logic [1:0]     gameState,
  input  logic           jumpBtn,
  input  logic           duckBtn,
  output logic [Y_W-1:0] dinoY,
  output logic           Airborne,
  output logic           onGround,
  output logic           isDuck,
  output logic           jumpStart
);

  // Typed constants so all physics arithmetic stays signed and width-exact.
  localparam logic signed [Y_W:0]   MAX_H_S = (Y_W+1)'(MAX_H);
  localparam logic signed [V_W+1:0] GRAV_S  = (V_W+2)'(GRAVITY);
  localparam logic signed [V_W+1:0] FAST_S  = (V_W+2)'(FAST_G);
  localparam logic signed [V_W+1:0] ZERO_S  = (V_W+2)'(0);
  localparam logic signed [V_W+1:0] CUT_S   = (V_W+2)'(CUT_V);
  localparam logic signed [V_W+1:0] VMIN_S  = (V_W+2)'(-(2 ** (V_W-1)));
  localparam logic signed [V_W-1:0] V0_S    = V_W'(JUMP_V0);

  logic jump_level, jump_rise, duck_level;

  motion_state_e          state_q, state_d;
  logic [Y_W-1:0]         h_q, h_d;
  logic signed [V_W-1:0]  v_q, v_d;
  logic                   launch;
  logic signed [Y_W:0]    sum;
  logic signed [V_W+1:0]  vn;

  btn_sync_edge u_jump (
    .clk   (clk),
    .rst   (rst),
    .tick  (frameTick),
    .btn   (jumpBtn),
    .level (jump_level),
    .rise  (jump_rise)
  );

  // Duck only needs the held level; its edge output is left open.
  btn_sync_edge u_duck (
    .clk   (clk),
    .rst   (rst),
    .tick  (frameTick),
    .btn   (duckBtn),
    .level (duck_level),
    .rise  ()
  );

  // Next motion state, height and velocity; everything holds between frame ticks.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    launch  = 1'b0;

    // Candidate position and velocity for an airborne frame.
    sum = $signed({1'b0, h_q}) + (Y_W+1)'(v_q);
    vn  = (V_W+2)'(v_q) - GRAV_S - (duck_level ? FAST_S : ZERO_S);
    if (vn < VMIN_S) vn = VMIN_S;
    if ((state_q == ST_RISE) && !jump_level && (vn > CUT_S)) vn = CUT_S;

    if (frameTick) begin
      case (gameState)
        GS_PLAY: begin
          case (state_q)
            ST_GROUND, ST_DUCK: begin
              if (jump_rise) begin
                state_d = ST_RISE;
                v_d     = V0_S;
                launch  = 1'b1;
              end else begin
                state_d = duck_level ? ST_DUCK : ST_GROUND;
              end
            end
            default: begin
              if (sum <= 0) begin
                // Landing frame: settle on the ground, never relaunch here.
                h_d     = '0;
                v_d     = '0;
                state_d = duck_level ? ST_DUCK : ST_GROUND;
              end else if (sum >= MAX_H_S) begin
                h_d     = Y_W'(MAX_H);
                v_d     = '0;
                state_d = ST_FALL;
              end else begin
                h_d     = sum[Y_W-1:0];
                v_d     = vn[V_W-1:0];
                state_d = (vn > 0) ? ST_RISE : ST_FALL;
              end
            end
          endcase
        end
        GS_OVER: begin
          // Game over freezes the dino in place.
        end
        default: begin
          state_d = ST_GROUND;
          h_d     = '0;
          v_d     = '0;
        end
      endcase
    end
  end

  // State registers with flags decoded from the next state so they are registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_GROUND;
      h_q       <= '0;
      v_q       <= '0;
      Airborne  <= 1'b0;
      onGround  <= 1'b1;
      isDuck    <= 1'b0;
      jumpStart <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      Airborne  <= is_air(state_d);
      onGround  <= !is_air(state_d);
      isDuck    <= (state_d == ST_DUCK);
      jumpStart <= launch;
    end
  end

  assign dinoY = h_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl: hand vector table, directed
// corner sequences and randomized frames against a behavioural model.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [1:0] game_state;
  logic       jump_btn;
  logic       duck_btn;
  logic [7:0] dino_y;
  logic       airborne, on_ground, is_duck, jump_start;

  int n_checks = 0;
  int n_pass   = 0;

  dino_motion_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frameTick (frame_tick),
    .gameState (game_state),
    .jumpBtn   (jump_btn),
    .duckBtn   (duck_btn),
    .dinoY     (dino_y),
    .Airborne  (airborne),
    .onGround  (on_ground),
    .isDuck    (is_duck),
    .jumpStart (jump_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: height/velocity in plain integers, dino described as
  // "in the air (going up or not)" or "on the ground (crouched or not)".
  int m_h, m_v;
  bit m_air, m_up, m_crouch, m_prev, m_js;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_air = 0; m_up = 0; m_crouch = 0; m_prev = 0; m_js = 0;
  endtask

  task automatic model_step(input bit j, input bit d, input logic [1:0] gs);
    int  sum, vn;
    bit  fresh;
    fresh = j && !m_prev;
    m_js  = 0;
    if (gs == 2'b10) begin
      if (!m_air) begin
        if (fresh) begin
          m_air = 1; m_up = 1; m_crouch = 0; m_v = 12; m_js = 1;
        end else begin
          m_crouch = d;
        end
      end else begin
        sum = m_h + m_v;
        vn  = m_v - 1 - (d ? 2 : 0);
        if (vn < -32) vn = -32;
        if (m_up && !j && vn > 4) vn = 4;
        if (sum <= 0) begin
          m_h = 0; m_v = 0; m_air = 0; m_crouch = d;
        end else if (sum >= 100) begin
          m_h = 100; m_v = 0; m_up = 0;
        end else begin
          m_h = sum; m_v = vn; m_up = (vn > 0);
        end
      end
    end else if (gs != 2'b01) begin
      m_h = 0; m_v = 0; m_air = 0; m_crouch = 0;
    end
    m_prev = j;
  endtask

  // One 10-clk frame: settle buttons, pulse frameTick, sample at the next falling edge.
  task automatic do_frame(input bit j, input bit d, input logic [1:0] gs, input bit cmp);
    jump_btn   = j;
    duck_btn   = d;
    game_state = gs;
    repeat (8) @(posedge clk);
    #1;
    check("hold_between_ticks", int'(dino_y), m_h);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    @(negedge clk);
    model_step(j, d, gs);
    if (cmp) begin
      check("model_dinoY",     int'(dino_y),     m_h);
      check("model_Airborne",  int'(airborne),   int'(m_air));
      check("model_onGround",  int'(on_ground),  int'(!m_air));
      check("model_isDuck",    int'(is_duck),    int'(!m_air && m_crouch));
      check("model_jumpStart", int'(jump_start), int'(m_js));
    end
  endtask

  typedef struct {
    bit         j;
    bit         d;
    logic [1:0] gs;
    int         y;
    bit         air;
    bit         gnd;
    bit         duck;
    bit         js;
  } vec_t;

  function automatic vec_t mk(input bit j, input bit d, input int y,
                              input bit air, input bit gnd, input bit duck, input bit js);
    vec_t v;
    v.j = j; v.d = d; v.gs = 2'b10; v.y = y;
    v.air = air; v.gnd = gnd; v.duck = duck; v.js = js;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    int peak, air_cnt, js_cnt, landed_at;

    // Ground, crouch, combined press (jump wins), held-jump climb, short hop,
    // apex, fast fall and a landing straight into a crouch.
    vecs[0]  = mk(0, 0,  0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 1,  0, 0, 1, 1, 0);
    vecs[2]  = mk(1, 1,  0, 1, 0, 0, 1);
    vecs[3]  = mk(1, 0, 12, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 23, 1, 0, 0, 0);
    vecs[5]  = mk(1, 0, 33, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 42, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 46, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 49, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 51, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 52, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 52, 1, 0, 0, 0);
    vecs[12] = mk(0, 1, 49, 1, 0, 0, 0);
    vecs[13] = mk(0, 1, 43, 1, 0, 0, 0);
    vecs[14] = mk(0, 1, 34, 1, 0, 0, 0);
    vecs[15] = mk(0, 1, 22, 1, 0, 0, 0);
    vecs[16] = mk(0, 1,  7, 1, 0, 0, 0);
    vecs[17] = mk(0, 1,  0, 0, 1, 1, 0);
    vecs[18] = mk(0, 0,  0, 0, 1, 0, 0);

    rst        = 1'b0;
    frame_tick = 1'b0;
    game_state = 2'b00;
    jump_btn   = 1'b0;
    duck_btn   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dinoY",     int'(dino_y),     0);
    check("reset_onGround",  int'(on_ground),  1);
    check("reset_Airborne",  int'(airborne),   0);
    check("reset_isDuck",    int'(is_duck),    0);
    check("reset_jumpStart", int'(jump_start), 0);
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      do_frame(vecs[i].j, vecs[i].d, vecs[i].gs, 1'b0);
      check($sformatf("vec%0d_dinoY", i),     int'(dino_y),     vecs[i].y);
      check($sformatf("vec%0d_Airborne", i),  int'(airborne),   int'(vecs[i].air));
      check($sformatf("vec%0d_onGround", i),  int'(on_ground),  int'(vecs[i].gnd));
      check($sformatf("vec%0d_isDuck", i),    int'(is_duck),    int'(vecs[i].duck));
      check($sformatf("vec%0d_jumpStart", i), int'(jump_start), int'(vecs[i].js));
    end

    // Full jump with the button held throughout.
    peak = 0; air_cnt = 0; js_cnt = 0; landed_at = -1;
    for (int f = 0; f < 40 && landed_at < 0; f++) begin
      do_frame(1'b1, 1'b0, 2'b10, 1'b1);
      if (airborne)   air_cnt++;
      if (jump_start) js_cnt++;
      if (int'(dino_y) > peak) peak = int'(dino_y);
      if (f > 0 && on_ground) landed_at = f;
    end
    check("full_peak",        peak,      78);
    check("full_air_frames",  air_cnt,   25);
    check("full_jumpstarts",  js_cnt,    1);
    check("full_land_tick",   landed_at, 25);

    // Held jump after landing needs a fresh edge: stays on the ground.
    for (int f = 0; f < 3; f++) begin
      do_frame(1'b1, 1'b0, 2'b10, 1'b1);
      check("held_no_relaunch", int'(airborne), 0);
    end

    // Game-over freeze mid-air, then resume, then forced back to ground by start screen.
    do_frame(1'b0, 1'b0, 2'b10, 1'b1);
    do_frame(1'b1, 1'b0, 2'b10, 1'b1);
    do_frame(1'b1, 1'b0, 2'b10, 1'b1);
    do_frame(1'b1, 1'b0, 2'b10, 1'b1);
    check("pre_freeze_y", int'(dino_y), 23);
    for (int f = 0; f < 20; f++) begin
      do_frame(1'b1, 1'b0, 2'b01, 1'b1);
      check("freeze_y", int'(dino_y), 23);
    end
    do_frame(1'b1, 1'b0, 2'b10, 1'b1);
    check("resume_y", int'(dino_y), 33);
    do_frame(1'b1, 1'b0, 2'b10, 1'b1);
    do_frame(1'b1, 1'b0, 2'b00, 1'b1);
    check("start_forces_y",      int'(dino_y),    0);
    check("start_forces_ground", int'(on_ground), 1);

    // Reset asserted mid-air at height 50.
    do_frame(1'b0, 1'b0, 2'b10, 1'b1);
    for (int f = 0; f < 6; f++) do_frame(1'b1, 1'b0, 2'b10, 1'b1);
    check("pre_reset_y", int'(dino_y), 50);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check("midair_reset_y",        int'(dino_y),     0);
    check("midair_reset_onGround", int'(on_ground),  1);
    check("midair_reset_Airborne", int'(airborne),   0);
    check("midair_reset_jstart",   int'(jump_start), 0);
    jump_btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_frame(1'b0, 1'b0, 2'b10, 1'b1);

    // Randomized frames against the model, plus flag invariants.
    for (int f = 0; f < 400; f++) begin
      int         r;
      logic [1:0] gs;
      r  = int'($urandom_range(0, 99));
      gs = (r < 86) ? 2'b10 : (r < 93) ? 2'b01 : (r < 97) ? 2'b00 : 2'b11;
      do_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), gs, 1'b1);
      check("inv_one_hot_air_ground", int'(airborne ^ on_ground), 1);
      check("inv_duck_on_ground",     int'(is_duck & ~on_ground), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dino_motion_ctrl.md
Name: dino_motion_ctrl

Overview:
Per-frame vertical-motion controller for the dino sprite.
- Turns synchronized jump/duck buttons and the global game state into jump physics: height, velocity and phase.
- Drives the Airborne / onGround / isDuck flags consumed by the dino sprite-select FSM.
- Drives the dinoY height used by the renderer and collision logic.
- Sits between the input debouncers and the sprite/render path; state updates only on frameTick.

Parameters:
Y_W, 8, width of dinoY (unsigned height above ground, pixels)
V_W, 6, width of signed velocity register
JUMP_V0, 12, launch velocity (px/frame)
GRAVITY, 1, velocity decrement per frame
FAST_G, 2, extra decrement per frame while duck held in air
CUT_V, 4, velocity cap after early jump release (short hop)
MAX_H, 100, height ceiling

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
frameTick  in  1  one-clk pulse per video frame
gameState  in  2  00 start screen, 01 game over, 10 playing, 11 treated as 00
jumpBtn  in  1  raw jump button, asynchronous
duckBtn  in  1  raw duck button, asynchronous
dinoY  out  Y_W  height above ground
Airborne  out  1  dino in RISE or FALL
onGround  out  1  dino in GROUND or DUCK
isDuck  out  1  dino in DUCK
jumpStart  out  1  one-clk pulse on launch (sound trigger)

Behaviour:
Reset (rst=0, async):
- state=GROUND, h=0, v=0.
- dinoY=0, onGround=1, Airborne=0, isDuck=0, jumpStart=0.
- Sync flops and jumpPrev cleared.

Input conditioning:
- Buttons pass a 2-flop synchronizer.
- jumpPrev is captured only on frameTick.
- jumpEdge = jumpSync & ~jumpPrev, evaluated at frameTick.

State machine: GROUND, DUCK, RISE, FALL. All transitions and arithmetic occur only on cycles with frameTick=1; otherwise all registers hold.

gameState handling:
- 00 or 11: force GROUND, h=0, v=0 every tick.
- 01: freeze. No updates, outputs hold, jumpPrev still tracks.
- 10: normal operation, rules below.

GROUND / DUCK:
- jumpEdge → RISE, v=JUMP_V0, h unchanged (0), jumpStart pulses this same clk.
- Jump has priority over duck.
- Otherwise next state = duckSync ? DUCK : GROUND.

RISE / FALL, per tick:
- sum = h + v, computed in signed Y_W+1 bits.
- vn = v − GRAVITY − (duckSync ? FAST_G : 0).
- Short hop: if state=RISE, jumpSync=0 and vn > CUT_V, then vn = CUT_V.
- Landing: sum ≤ 0 → h=0, v=0, next state = duckSync ? DUCK : GROUND. Landing tick never launches; a new jump needs a fresh edge on a later tick.
- Ceiling: sum ≥ MAX_H → h=MAX_H, v=0, FALL.
- Otherwise h=sum, v=vn, next state = (vn > 0) ? RISE : FALL.
- v saturates at −2^(V_W−1); it never wraps.

Outputs:
- Registered, decoded from state. Valid the clk after the frameTick that changed state.
- Exactly one of Airborne/onGround is 1 at all times. isDuck implies onGround.

Reset mid-jump: immediate return to reset values, no landing event.

Decomposition:
- Shared package dino_pkg holds the gameState encodings (GS_START, GS_OVER, GS_PLAY) and the motion-state encoding.
- dino_pkg also holds the sprite-select codes used by the sprite FSM, so both blocks agree.
- One sub-module: btn_sync_edge. 2-flop synchronizer plus frame-gated previous-value register; outputs level and rising edge. Instanced for jump (edge used) and duck (level used).

Test Plan:
1. Defaults, gameState=10, jump pressed and held, frameTick every 10 clks:
   - jumpStart pulses once.
   - dinoY sequence 12, 23, 33, …, peaks at 78 after 12 ticks.
   - FALL from tick 12, dinoY=0 and onGround=1 at tick 25.
   - Airborne high for exactly 25 ticks.
2. Short hop: release jump after 3 ticks (dinoY=33) → v capped to 4, peak < 78, lands earlier than tick 25.
3. Fast fall: hold duck from apex → descent uses −3/frame, lands before tick 25; lands into DUCK (isDuck=1) if duck still held.
4. Jump and duck asserted together on ground → RISE (jump wins), isDuck=0.
5. Held jump with no new edge after landing → stays GROUND. gameState=01 mid-air → dinoY frozen for 20 ticks, resumes on 10.
6. rst low mid-air (dinoY=50) → next clk dinoY=0, onGround=1. gameState=00 mid-air → GROUND on next tick.
